// File: rtl/serial_bus_master_port.sv
// Master-side serial transaction engine: serialises start/ID/offset/data onto a
// single-wire pulled-up bus, then waits for slave acks or a returned read byte.
module serial_bus_master_port #(
    parameter int ADDRESS_WIDTH = 15,
    parameter int DATA_WIDTH    = 8,
    parameter int ACK_TIMEOUT   = 16,
    parameter int READ_TIMEOUT  = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic                     bus_grant,
    input  logic                     rd_wrt,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     done,
    output logic                     error,
    output logic                     busy,
    output logic                     bus_util,
    output logic                     rd_wrt_bus,
    input  logic                     slave_busy,
    inout  wire                      data_bus_serial
);

    localparam int OFS_W   = ADDRESS_WIDTH - 3;
    localparam int TX_W    = (ADDRESS_WIDTH > DATA_WIDTH) ? ADDRESS_WIDTH + 2 : DATA_WIDTH + 2;
    localparam int CNT_W   = $clog2(TX_W);
    localparam int TMO_MAX = (ACK_TIMEOUT > READ_TIMEOUT) ? ACK_TIMEOUT : READ_TIMEOUT;
    localparam int TMO_W   = $clog2(TMO_MAX + 1);

    localparam logic [TMO_W-1:0] ACK_LIM  = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] READ_LIM = TMO_W'(READ_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_SAT  = {TMO_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_SEND_ID,
        S_SEND_ADDR,
        S_WAIT_ADDR_ACK,
        S_SEND_DATA,
        S_WAIT_DATA_ACK,
        S_WAIT_READ_DATA,
        S_RX_DATA,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic                    prev_zero_q, prev_zero_d;
    logic [TX_W-1:0]         tx_sr_q, tx_sr_d;
    logic                    drive_en_q, drive_en_d;
    logic [DATA_WIDTH-2:0]   rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    rd_wrt_q, rd_wrt_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    busy_q, busy_d;
    logic                    bus_util_q, bus_util_d;
    logic                    rd_wrt_bus_q, rd_wrt_bus_d;

    logic                    is_zero_s;
    logic                    bus_bit_s;
    logic [TMO_W-1:0]        tmo_inc_s;
    logic                    unused_slave_busy_s;

    // The line idles high through the pull-up, so anything not driven low reads as 1.
    assign is_zero_s           = (data_bus_serial == 1'b0);
    assign bus_bit_s           = ~is_zero_s;
    assign tmo_inc_s           = (tmo_q == TMO_SAT) ? tmo_q : tmo_q + TMO_W'(1);
    assign unused_slave_busy_s = slave_busy;

    assign data_bus_serial = drive_en_q ? tx_sr_q[TX_W-1] : 1'bz;
    assign rd_data         = rd_data_q;
    assign done            = done_q;
    assign error           = error_q;
    assign busy            = busy_q;
    assign bus_util        = bus_util_q;
    assign rd_wrt_bus      = rd_wrt_bus_q;

    // Next-state, shift-register and output-flop computation.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tmo_d       = tmo_q;
        prev_zero_d = prev_zero_q;
        tx_sr_d     = tx_sr_q;
        drive_en_d  = drive_en_q;
        rx_sr_d     = rx_sr_q;
        rd_data_d   = rd_data_q;
        wr_data_d   = wr_data_q;
        rd_wrt_d    = rd_wrt_q;

        case (state_q)
            S_IDLE: begin
                drive_en_d = 1'b0;
                if (req && bus_grant) begin
                    state_d    = S_START;
                    rd_wrt_d   = rd_wrt;
                    wr_data_d  = wr_data;
                    tx_sr_d    = TX_W'({2'b00, addr}) << (TX_W - ADDRESS_WIDTH - 2);
                    bit_cnt_d  = CNT_W'(1);
                    drive_en_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                tx_sr_d = tx_sr_q << 1;
                if (bit_cnt_q == CNT_ZERO) begin
                    state_d   = S_SEND_ID;
                    bit_cnt_d = CNT_W'(2);
                end else begin
                    bit_cnt_d = bit_cnt_q - CNT_W'(1);
                end
            end
            S_SEND_ID: begin
                tx_sr_d = tx_sr_q << 1;
                if (bit_cnt_q == CNT_ZERO) begin
                    state_d   = S_SEND_ADDR;
                    bit_cnt_d = CNT_W'(OFS_W - 1);
                end else begin
                    bit_cnt_d = bit_cnt_q - CNT_W'(1);
                end
            end
            S_SEND_ADDR: begin
                tx_sr_d = tx_sr_q << 1;
                if (bit_cnt_q == CNT_ZERO) begin
                    state_d     = S_WAIT_ADDR_ACK;
                    drive_en_d  = 1'b0;
                    tmo_d       = {TMO_W{1'b0}};
                    prev_zero_d = 1'b0;
                end else begin
                    bit_cnt_d = bit_cnt_q - CNT_W'(1);
                end
            end
            S_WAIT_ADDR_ACK: begin
                // Two consecutive low samples form the ack; an ack on the last allowed sample still wins.
                prev_zero_d = is_zero_s;
                if (is_zero_s && prev_zero_q) begin
                    tmo_d = {TMO_W{1'b0}};
                    if (rd_wrt_q) begin
                        state_d    = S_SEND_DATA;
                        tx_sr_d    = TX_W'({2'b10, wr_data_q}) << (TX_W - DATA_WIDTH - 2);
                        bit_cnt_d  = CNT_W'(DATA_WIDTH + 1);
                        drive_en_d = 1'b1;
                    end else begin
                        state_d = S_WAIT_READ_DATA;
                    end
                end else if (tmo_q == ACK_LIM) begin
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_inc_s;
                end
            end
            S_SEND_DATA: begin
                tx_sr_d = tx_sr_q << 1;
                if (bit_cnt_q == CNT_ZERO) begin
                    state_d     = S_WAIT_DATA_ACK;
                    drive_en_d  = 1'b0;
                    tmo_d       = {TMO_W{1'b0}};
                    prev_zero_d = 1'b0;
                end else begin
                    bit_cnt_d = bit_cnt_q - CNT_W'(1);
                end
            end
            S_WAIT_DATA_ACK: begin
                prev_zero_d = is_zero_s;
                if (bus_bit_s && prev_zero_q) begin
                    state_d = S_DONE;
                end else if (tmo_q == ACK_LIM) begin
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_inc_s;
                end
            end
            S_WAIT_READ_DATA: begin
                if (is_zero_s) begin
                    state_d   = S_RX_DATA;
                    bit_cnt_d = CNT_W'(DATA_WIDTH - 1);
                end else if (tmo_q == READ_LIM) begin
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_inc_s;
                end
            end
            S_RX_DATA: begin
                rx_sr_d = {rx_sr_q[DATA_WIDTH-3:0], bus_bit_s};
                if (bit_cnt_q == CNT_ZERO) begin
                    state_d   = S_DONE;
                    rd_data_d = {rx_sr_q, bus_bit_s};
                end else begin
                    bit_cnt_d = bit_cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERROR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                drive_en_d = 1'b0;
            end
        endcase

        // Status flops follow the state being entered so they line up with it.
        busy_d       = (state_d != S_IDLE);
        bus_util_d   = (state_d != S_IDLE);
        rd_wrt_bus_d = (state_d != S_IDLE) & rd_wrt_d;
        done_d       = (state_d == S_DONE);
        error_d      = (state_d == S_ERROR);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= {CNT_W{1'b0}};
            tmo_q        <= {TMO_W{1'b0}};
            prev_zero_q  <= 1'b0;
            tx_sr_q      <= {TX_W{1'b0}};
            drive_en_q   <= 1'b0;
            rx_sr_q      <= {(DATA_WIDTH-1){1'b0}};
            rd_data_q    <= {DATA_WIDTH{1'b0}};
            wr_data_q    <= {DATA_WIDTH{1'b0}};
            rd_wrt_q     <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
            bus_util_q   <= 1'b0;
            rd_wrt_bus_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            tmo_q        <= tmo_d;
            prev_zero_q  <= prev_zero_d;
            tx_sr_q      <= tx_sr_d;
            drive_en_q   <= drive_en_d;
            rx_sr_q      <= rx_sr_d;
            rd_data_q    <= rd_data_d;
            wr_data_q    <= wr_data_d;
            rd_wrt_q     <= rd_wrt_d;
            done_q       <= done_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
            bus_util_q   <= bus_util_d;
            rd_wrt_bus_q <= rd_wrt_bus_d;
        end
    end

endmodule

// File: tb/tb_serial_bus_master_port.sv
// Bench for serial_bus_master_port: a scheduled slave drives the pulled-up bus and
// expected frames/timings are derived from the protocol's cycle arithmetic.
module tb_serial_bus_master_port;

    localparam int ACK_T = 16;
    localparam int RD_T  = 255;

    logic        clk = 1'b0;
    logic        rst, req, bus_grant, rd_wrt, slave_busy;
    logic [14:0] addr;
    logic [7:0]  wr_data;
    wire  [7:0]  rd_data;
    wire         done, error, busy, bus_util, rd_wrt_bus;
    wire         data_bus_serial;
    logic        slv_en, slv_val;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_rd  = 8'h00;
    logic        sched_en [0:1023];
    logic        sched_v  [0:1023];

    always #5 clk = ~clk;

    assign data_bus_serial = slv_en ? slv_val : 1'bz;
    pullup (data_bus_serial);

    serial_bus_master_port dut (
        .clk(clk), .rst(rst), .req(req), .bus_grant(bus_grant), .rd_wrt(rd_wrt),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .done(done), .error(error),
        .busy(busy), .bus_util(bus_util), .rd_wrt_bus(rd_wrt_bus),
        .slave_busy(slave_busy), .data_bus_serial(data_bus_serial)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sched_zero(input int n);
        sched_en[n] = 1'b1;
        sched_v[n]  = 1'b0;
    endtask

    // One transaction; ack_d/resp_d < 0 means the slave stays silent.
    task automatic run_txn(input logic wr, input logic [14:0] a, input logic [7:0] wd,
                           input int ack_d, input int glitch, input int resp_d,
                           input logic [7:0] rb, input logic hold_req);
        int   acc, last;
        logic ok;
        logic [7:0] rd_after;
        logic exp_b;
        logic known;
        for (int i = 0; i < 1024; i++) begin
            sched_en[i] = 1'b0;
            sched_v[i]  = 1'b1;
        end
        acc = -100;
        ok  = 1'b0;
        if (glitch >= 0) sched_zero(17 + glitch);
        if (ack_d < 0) begin
            last = 17 + ACK_T;
        end else begin
            sched_zero(17 + ack_d);
            sched_zero(18 + ack_d);
            acc = 19 + ack_d;
            if (wr) begin
                if (resp_d >= 0) begin
                    sched_zero(acc + 10 + resp_d);
                    last = acc + 10 + resp_d + 2;
                    ok   = 1'b1;
                end else begin
                    last = acc + 10 + ACK_T;
                end
            end else begin
                if (resp_d >= 0) begin
                    sched_zero(acc + resp_d);
                    for (int k = 0; k < 8; k++) begin
                        sched_en[acc + resp_d + 1 + k] = 1'b1;
                        sched_v[acc + resp_d + 1 + k]  = rb[7-k];
                    end
                    last = acc + resp_d + 9;
                    ok   = 1'b1;
                end else begin
                    last = acc + RD_T;
                end
            end
        end
        rd_after = (!wr && ok) ? rb : exp_rd;

        req = 1'b1; bus_grant = 1'b1; rd_wrt = wr; addr = a; wr_data = wd;
        @(posedge clk);
        for (int n = 0; n <= last + 1; n++) begin
            @(negedge clk);
            if (n == 0) begin
                if (!hold_req) req = 1'b0;
                addr    = 15'($urandom);
                wr_data = 8'($urandom);
                rd_wrt  = 1'($urandom);
            end
            slv_en  = sched_en[n];
            slv_val = sched_v[n];
            #1;
            known = 1'b0;
            exp_b = 1'b1;
            if (n <= 1) begin
                known = 1'b1; exp_b = 1'b0;
            end else if (n <= 4) begin
                known = 1'b1; exp_b = a[14 - (n - 2)];
            end else if (n <= 16) begin
                known = 1'b1; exp_b = a[11 - (n - 5)];
            end else if (wr && n >= acc && n < acc + 10) begin
                known = 1'b1;
                exp_b = (n == acc) ? 1'b1 : (n == acc + 1) ? 1'b0 : wd[7 - (n - acc - 2)];
            end else if (n == last + 1) begin
                known = 1'b1; exp_b = 1'b1;
            end
            if (known) check_eq("bus_bit", 32'(data_bus_serial), 32'(exp_b));
            if (n < last) begin
                check_eq("status_active", 32'({busy, bus_util, rd_wrt_bus, done, error}),
                         32'({1'b1, 1'b1, wr, 1'b0, 1'b0}));
                check_eq("rd_data_hold", 32'(rd_data), 32'(exp_rd));
            end else if (n == last) begin
                check_eq("status_end", 32'({busy, bus_util, rd_wrt_bus, done, error}),
                         32'({1'b1, 1'b1, wr, ok, ~ok}));
                check_eq("rd_data_end", 32'(rd_data), 32'(rd_after));
            end else begin
                check_eq("status_release", 32'({busy, bus_util, rd_wrt_bus, done, error}), 32'(0));
                check_eq("rd_data_after", 32'(rd_data), 32'(rd_after));
            end
        end
        exp_rd = rd_after;
        slv_en = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   ad, gl, rsp;
        logic wr;
        rst = 1'b1; req = 1'b0; bus_grant = 1'b0; rd_wrt = 1'b0; slave_busy = 1'b0;
        addr = 15'h0000; wr_data = 8'h00; slv_en = 1'b0; slv_val = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_status", 32'({busy, bus_util, rd_wrt_bus, done, error}), 32'(0));
        check_eq("reset_rd_data", 32'(rd_data), 32'(0));
        check_eq("reset_bus", 32'(data_bus_serial), 32'(1));
        rst = 1'b0;
        @(negedge clk); #1;

        run_txn(1'b1, 15'h30A5, 8'hC3, 4, -1, 3, 8'h00, 1'b0);
        run_txn(1'b0, 15'h5123, 8'h00, 2, -1, 40, 8'h5A, 1'b0);
        run_txn(1'b0, 15'h7FFF, 8'h00, -1, -1, -1, 8'h00, 1'b0);
        run_txn(1'b1, 15'h1234, 8'hA5, 6, 1, 2, 8'h00, 1'b0);
        run_txn(1'b0, 15'h2ABC, 8'h00, 3, -1, -1, 8'h00, 1'b0);
        run_txn(1'b1, 15'h4321, 8'h0F, 14, -1, 14, 8'h00, 1'b1);
        run_txn(1'b0, 15'h6001, 8'h00, 0, -1, 0, 8'h81, 1'b0);

        // Request without grant is dropped.
        req = 1'b1; bus_grant = 1'b0; rd_wrt = 1'b1; addr = 15'h3333;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check_eq("no_grant_busy", 32'({busy, bus_util}), 32'(0));
        end
        req = 1'b0; bus_grant = 1'b1;
        @(negedge clk); #1;
        check_eq("dropped_req", 32'({busy, bus_util}), 32'(0));

        // Reset in the middle of the offset field.
        req = 1'b1; rd_wrt = 1'b1; addr = 15'h7A5A; wr_data = 8'h3C;
        @(posedge clk);
        for (int n = 0; n <= 10; n++) begin
            @(negedge clk);
            req = 1'b0;
            #1;
        end
        check_eq("pre_reset_busy", 32'(busy), 32'(1));
        rst = 1'b1;
        @(negedge clk); #1;
        check_eq("midreset_status", 32'({busy, bus_util, rd_wrt_bus, done, error}), 32'(0));
        check_eq("midreset_bus", 32'(data_bus_serial), 32'(1));
        check_eq("midreset_rd_data", 32'(rd_data), 32'(0));
        exp_rd = 8'h00;
        rst = 1'b0;
        run_txn(1'b0, 15'h5123, 8'h00, 5, 2, 7, 8'hE7, 1'b0);

        for (int t = 0; t < 10; t++) begin
            wr  = 1'($urandom);
            ad  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 14));
            gl  = (ad >= 2 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, ad - 2)) : -1;
            if (wr) rsp = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 14));
            else    rsp = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 80));
            run_txn(wr, 15'($urandom), 8'($urandom), ad, gl, rsp, 8'($urandom), 1'($urandom));
        end

        req = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_bus_master_port.md
Name: serial_bus_master_port

Overview:
- Master-side serial transaction engine; the block directly upstream of each slave on the single-wire serial data bus.
- Accepts one parallel read or write request from a bus master.
- Serialises start bits, slave ID, address offset and (for writes) the data byte onto the bus, then waits for the slave's acks.
- For reads, deserialises the returned byte and reports done or a timeout error.

Parameters:
- ADDRESS_WIDTH, 15: full address; top 3 bits are the slave ID, lower ADDRESS_WIDTH-3 bits are the offset.
- DATA_WIDTH, 8: data byte width.
- ACK_TIMEOUT, 16: maximum cycles to wait for an address or data ack.
- READ_TIMEOUT, 255: maximum cycles to wait for the read-data start bit.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  start a transaction; sampled only in IDLE.
- bus_grant  in  1  arbiter grant; req is ignored unless this is high.
- rd_wrt  in  1  1 = write to slave, 0 = read from slave; latched with req.
- addr  in  ADDRESS_WIDTH  [14:12] slave ID, [11:0] offset; latched with req.
- wr_data  in  DATA_WIDTH  write byte; latched with req.
- rd_data  out  DATA_WIDTH  last read byte; held until the next read completes.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on a timeout.
- busy  out  1  high from req acceptance until the done/error cycle inclusive.
- bus_util  out  1  high while this master owns the bus.
- rd_wrt_bus  out  1  latched rd_wrt, driven while bus_util is high, else 0.
- slave_busy  in  1  wired busy line from the slaves (monitor only).
- data_bus_serial  inout  1  serial bus; driven 0/1 or Z; idles high via external pull-up.

Behaviour:
- Reset (rst high at a clk edge):
  - state IDLE; data_bus_serial Z.
  - bus_util, rd_wrt_bus, done, error, busy all 0; rd_data 0; all counters 0.
  - Reset mid-transaction aborts immediately: the bus is released the same edge and no done/error pulse is produced.
- Bit timing: one bit per clk, MSB first. Every bus sample is the value on data_bus_serial at the posedge.
- IDLE:
  - Bus is Z.
  - If req && bus_grant: latch rd_wrt/addr/wr_data; set busy=1, bus_util=1; go to START.
  - req without bus_grant is dropped and must be re-asserted.
- START: drive 0 for 2 cycles.
- SEND_ID: drive addr[14:12], 3 cycles.
- SEND_ADDR: drive addr[11:0], 12 cycles. The first transmitted bit appears 1 cycle after acceptance.
- WAIT_ADDR_ACK:
  - Release the bus (Z); a cycle counter starts at 0.
  - Ack = bus sampled 0 on two consecutive cycles.
  - On ack: if rd_wrt=1 go to SEND_DATA, else go to WAIT_READ_DATA.
  - If the counter reaches ACK_TIMEOUT without an ack, go to ERROR.
  - A single isolated 0 does not count as an ack; the consecutive-zero count resets on a 1.
- SEND_DATA:
  - Drive 1 (guard) for 1 cycle, then 0 (start) for 1 cycle, then wr_data MSB..LSB for DATA_WIDTH cycles, then release.
- WAIT_DATA_ACK:
  - Bus is Z; counter restarts.
  - Ack = a cycle sampled 0 followed by a cycle sampled 1.
  - On ack go to DONE; on counter reaching ACK_TIMEOUT go to ERROR.
- WAIT_READ_DATA:
  - Bus is Z; counter restarts; slave_busy is ignored for decisions.
  - First cycle sampled 0 is the start bit; go to RX_DATA.
  - If the counter reaches READ_TIMEOUT, go to ERROR.
- RX_DATA:
  - Shift DATA_WIDTH samples MSB first.
  - rd_data updates on the cycle the last bit is sampled; go to DONE.
- DONE: done=1 for one cycle; bus_util=0, rd_wrt_bus=0, busy=0 on the next cycle; return to IDLE.
- ERROR: error=1 for one cycle; same release sequence as DONE; rd_data is unchanged.
- Counter rules:
  - Timeout counters are wide enough for READ_TIMEOUT and saturate; there is no wrap-around.
  - Bit counters count down from width-1 to 0.
- Back-to-back transactions: req is held high through DONE, and the next transaction is accepted no earlier than the IDLE cycle after DONE.
- Contention: while the engine is driving the bus it never samples the bus for decisions.

Test Plan:
- Write: addr=15'h3_0A5 (ID 3), wr_data=8'hC3; slave model acks addr at cycle +4 and data at +3 -> bus shows 0,0,0,1,1,0000_1010_0101, then 1,0,1100_0011; done pulses once; error stays 0.
- Read: addr=15'h5_123; addr ack; slave returns start 0 then 8'h5A after 40 cycles -> rd_data=8'h5A on the done cycle; busy falls the next cycle.
- Address ack timeout: no slave responds -> error pulses exactly ACK_TIMEOUT cycles after bus release; bus Z; rd_data unchanged.
- Glitch rejection: a single 0 then 1 during WAIT_ADDR_ACK, then a valid ack later -> only the valid ack advances the FSM.
- Read timeout: addr acked, no start bit -> error after READ_TIMEOUT cycles; done never pulses.
- Reset mid-SEND_ADDR: rst asserted at bit 6 -> next edge bus Z, bus_util=0, busy=0, no pulses; a new req is accepted cleanly afterwards.
